// File: rtl/issue_scoreboard_ctrl.sv
// Issue gate between decode stage 1 and decode stage 2: tracks pending register
// writers and the in-flight window, and holds back RAW hazards and serializing ops.
module issue_scoreboard_ctrl #(
  parameter int MAX_INFLIGHT = 4,
  parameter int PCNT_W       = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id1_valid_i,
  input  logic [4:0]  id1_rs1_i,
  input  logic [4:0]  id1_rs2_i,
  input  logic        id1_use_rs1_i,
  input  logic        id1_use_rs2_i,
  input  logic [4:0]  id1_rd_i,
  input  logic        id1_gr_we_i,
  input  logic        id1_serial_i,
  output logic        id1_ready_o,
  output logic        id2_valid_o,
  input  logic        wb_release_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        wb_gr_we_i,
  input  logic        flush_i,
  output logic [2:0]  inflight_o,
  output logic [31:0] busy_vec_o,
  output logic [1:0]  state_o,
  output logic        underflow_o
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HAZARD = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  localparam logic [PCNT_W-1:0] CNT_MAX = '1;
  localparam logic [2:0]        INF_MAX = 3'(MAX_INFLIGHT);

  logic [PCNT_W-1:0] cnt_q   [32];
  logic [PCNT_W-1:0] cnt_d   [32];
  logic [PCNT_W-1:0] cnt_eff [32];
  logic [31:0]       cnt_dec;
  logic [31:0]       cnt_inc;
  logic [2:0]        inflight_q, inflight_d, inf_eff;
  logic              inf_dec;
  logic              underflow_q, underflow_d;
  state_e            state_q;
  logic              raw, waw_full, full, drain, issue;

  // A same-cycle writeback frees its register and window slot for this cycle's issue.
  always_comb begin : eff_counts
    inf_dec = wb_release_i && (inflight_q != 3'd0);
    inf_eff = inflight_q - 3'(inf_dec);
    cnt_dec = '0;
    for (int r = 0; r < 32; r++) begin
      cnt_dec[r] = wb_release_i && wb_gr_we_i && (wb_rd_i == 5'(r)) && (cnt_q[r] != '0);
      cnt_eff[r] = cnt_q[r] - PCNT_W'(cnt_dec[r]);
    end
  end

  always_comb begin : hazards
    raw      = (id1_use_rs1_i && (id1_rs1_i != 5'd0) && (cnt_eff[id1_rs1_i] != '0)) ||
               (id1_use_rs2_i && (id1_rs2_i != 5'd0) && (cnt_eff[id1_rs2_i] != '0));
    waw_full = id1_gr_we_i && (id1_rd_i != 5'd0) && (cnt_eff[id1_rd_i] == CNT_MAX);
    full     = (inf_eff == INF_MAX);
    drain    = id1_serial_i && (inf_eff != 3'd0);
    issue    = id1_valid_i && !flush_i && !raw && !waw_full && !full && !drain;
  end

  // Handshake: id1_ready_o and id2_valid_o are one signal; an instruction moves from
  // stage 1 to stage 2 on every rising edge where it is high, and stage 1 holds otherwise.
  assign id2_valid_o = issue && rst_i;
  assign id1_ready_o = issue && rst_i;

  always_comb begin : next_counts
    inflight_d = inflight_q + 3'(issue) - 3'(inf_dec);
    cnt_inc    = '0;
    for (int r = 0; r < 32; r++) begin
      cnt_inc[r] = issue && id1_gr_we_i && (id1_rd_i == 5'(r)) && (r != 0);
      cnt_d[r]   = cnt_q[r] + PCNT_W'(cnt_inc[r]) - PCNT_W'(cnt_dec[r]);
    end
    underflow_d = underflow_q ||
                  (wb_release_i && ((inflight_q == 3'd0) ||
                                    (wb_gr_we_i && (cnt_q[wb_rd_i] == '0))));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
      inflight_q  <= 3'd0;
      underflow_q <= 1'b0;
      state_q     <= ST_RUN;
    end else begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
      inflight_q  <= inflight_d;
      underflow_q <= underflow_d;
      // Diagnostic state only; issue never depends on it.
      if (flush_i)                           state_q <= ST_RUN;
      else if (id1_valid_i && !issue && drain) state_q <= ST_DRAIN;
      else if (id1_valid_i && !issue)        state_q <= ST_HAZARD;
      else                                   state_q <= ST_RUN;
    end
  end

  always_comb begin : busy_map
    busy_vec_o = '0;
    for (int r = 0; r < 32; r++) busy_vec_o[r] = (cnt_q[r] != '0);
  end

  assign inflight_o  = inflight_q;
  assign underflow_o = underflow_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_issue_scoreboard_ctrl.sv
// Bench for issue_scoreboard_ctrl: directed scenarios plus random traffic, checked
// against an integer reference model through an expected-issue queue.
module tb_issue_scoreboard_ctrl;

  localparam int MAX_INF = 4;
  localparam int CMAX    = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id1_valid_i, id1_use_rs1_i, id1_use_rs2_i, id1_gr_we_i, id1_serial_i;
  logic [4:0]  id1_rs1_i, id1_rs2_i, id1_rd_i, wb_rd_i;
  logic        wb_release_i, wb_gr_we_i, flush_i;
  logic        id1_ready_o, id2_valid_o, underflow_o;
  logic [2:0]  inflight_o;
  logic [31:0] busy_vec_o;
  logic [1:0]  state_o;

  issue_scoreboard_ctrl #(.MAX_INFLIGHT(MAX_INF), .PCNT_W(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id1_valid_i(id1_valid_i), .id1_rs1_i(id1_rs1_i), .id1_rs2_i(id1_rs2_i),
    .id1_use_rs1_i(id1_use_rs1_i), .id1_use_rs2_i(id1_use_rs2_i),
    .id1_rd_i(id1_rd_i), .id1_gr_we_i(id1_gr_we_i), .id1_serial_i(id1_serial_i),
    .id1_ready_o(id1_ready_o), .id2_valid_o(id2_valid_o),
    .wb_release_i(wb_release_i), .wb_rd_i(wb_rd_i), .wb_gr_we_i(wb_gr_we_i),
    .flush_i(flush_i), .inflight_o(inflight_o), .busy_vec_o(busy_vec_o),
    .state_o(state_o), .underflow_o(underflow_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [0:0] exp_q[$];
  logic       last_issue;

  int m_cnt[32];
  int m_inf;
  bit m_uf;
  int m_state;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_inf   = 0;
    m_uf    = 1'b0;
    m_state = 0;
  endtask

  function automatic int eff_cnt(input logic [4:0] idx);
    int c;
    c = m_cnt[idx];
    if (wb_release_i && wb_gr_we_i && wb_rd_i == idx && c > 0) c = c - 1;
    return c;
  endfunction

  function automatic int eff_inf();
    return (wb_release_i && m_inf > 0) ? m_inf - 1 : m_inf;
  endfunction

  function automatic logic model_issue();
    bit raw, waw, full, drn;
    raw  = (id1_use_rs1_i && id1_rs1_i != 0 && eff_cnt(id1_rs1_i) > 0) ||
           (id1_use_rs2_i && id1_rs2_i != 0 && eff_cnt(id1_rs2_i) > 0);
    waw  = id1_gr_we_i && id1_rd_i != 0 && eff_cnt(id1_rd_i) == CMAX;
    full = eff_inf() == MAX_INF;
    drn  = id1_serial_i && eff_inf() != 0;
    return id1_valid_i && !flush_i && !raw && !waw && !full && !drn;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    for (int r = 0; r < 32; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  // Called right after the rising edge, with inputs still holding pre-edge values.
  task automatic model_update(input logic iss);
    bit drn;
    drn = id1_serial_i && eff_inf() != 0;
    if (flush_i)                     m_state = 0;
    else if (id1_valid_i && !iss && drn) m_state = 2;
    else if (id1_valid_i && !iss)    m_state = 1;
    else                             m_state = 0;
    if (wb_release_i) begin
      if (m_inf == 0) m_uf = 1'b1;
      else            m_inf--;
      if (wb_gr_we_i) begin
        if (m_cnt[wb_rd_i] == 0) m_uf = 1'b1;
        else                     m_cnt[wb_rd_i]--;
      end
    end
    if (iss) begin
      m_inf++;
      if (id1_gr_we_i && id1_rd_i != 0) m_cnt[id1_rd_i]++;
    end
  endtask

  // driver: one cycle of stimulus, starting and ending at a falling edge
  task automatic cyc(input bit v, input logic [4:0] rs1, input bit u1,
                     input logic [4:0] rs2, input bit u2, input logic [4:0] rd,
                     input bit we, input bit ser, input bit rel,
                     input logic [4:0] wrd, input bit wwe, input bit fl);
    logic exp_iss;
    id1_valid_i = v;   id1_rs1_i = rs1; id1_use_rs1_i = u1;
    id1_rs2_i   = rs2; id1_use_rs2_i = u2; id1_rd_i = rd;
    id1_gr_we_i = we;  id1_serial_i = ser;
    wb_release_i = rel; wb_rd_i = wrd; wb_gr_we_i = wwe; flush_i = fl;
    exp_iss = model_issue();
    exp_q.push_back(exp_iss);
    #2;
    last_issue = id2_valid_o;
    exp_iss = exp_q.pop_front();
    check_eq("id2_valid", {31'b0, id2_valid_o}, {31'b0, exp_iss});
    check_eq("id1_ready", {31'b0, id1_ready_o}, {31'b0, exp_iss});
    @(posedge clk_i);
    model_update(exp_iss);
    #1;
    check_eq("inflight",  {29'b0, inflight_o}, 32'(m_inf));
    check_eq("busy_vec",  busy_vec_o, model_busy());
    check_eq("underflow", {31'b0, underflow_o}, {31'b0, m_uf});
    check_eq("state",     {30'b0, state_o}, 32'(m_state));
    @(negedge clk_i);
  endtask

  task automatic issue_op(input logic [4:0] rs1, input bit u1, input logic [4:0] rd, input bit we);
    cyc(1, rs1, u1, 5'd0, 0, rd, we, 0, 0, 5'd0, 0, 0);
  endtask

  task automatic release_op(input logic [4:0] wrd, input bit wwe);
    cyc(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, wrd, wwe, 0);
  endtask

  initial begin
    rst_i = 1'b0;
    id1_valid_i = 1'b1; id1_rs1_i = 5'd5; id1_use_rs1_i = 1'b1;
    id1_rs2_i = '0; id1_use_rs2_i = 1'b0; id1_rd_i = '0; id1_gr_we_i = 1'b0;
    id1_serial_i = 1'b0; wb_release_i = 1'b0; wb_rd_i = '0; wb_gr_we_i = 1'b0;
    flush_i = 1'b0;
    model_reset();
    #12;
    check_eq("rst_id2_valid", {31'b0, id2_valid_o}, 32'd0);
    check_eq("rst_id1_ready", {31'b0, id1_ready_o}, 32'd0);
    check_eq("rst_inflight",  {29'b0, inflight_o}, 32'd0);
    check_eq("rst_state",     {30'b0, state_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // x0 is never tracked
    issue_op(5'd0, 0, 5'd0, 1);
    check_eq("x0_inflight", {29'b0, inflight_o}, 32'd1);
    issue_op(5'd0, 1, 5'd3, 0);
    check_eq("x0_no_stall", {31'b0, last_issue}, 32'd1);
    check_eq("x0_busy0",    {31'b0, busy_vec_o[0]}, 32'd0);
    issue_op(5'd1, 0, 5'd0, 0);
    check_eq("pre_rst_inflight", {29'b0, inflight_o}, 32'd3);

    // asynchronous reset in mid-cycle with a clean request on the bus
    id1_valid_i = 1'b1; id1_rs1_i = 5'd5; id1_use_rs1_i = 1'b1;
    #1;
    rst_i = 1'b0;
    #1;
    check_eq("arst_id2_valid",  {31'b0, id2_valid_o}, 32'd0);
    check_eq("arst_id1_ready",  {31'b0, id1_ready_o}, 32'd0);
    check_eq("arst_inflight",   {29'b0, inflight_o}, 32'd0);
    check_eq("arst_busy",       busy_vec_o, 32'd0);
    check_eq("arst_underflow",  {31'b0, underflow_o}, 32'd0);
    check_eq("arst_state",      {30'b0, state_o}, 32'd0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    issue_op(5'd5, 1, 5'd0, 0);
    check_eq("post_rst_issue", {31'b0, last_issue}, 32'd1);
    check_eq("post_rst_busy",  busy_vec_o, 32'd0);
    release_op(5'd0, 0);

    // RAW stall, freed by a same-cycle writeback
    issue_op(5'd0, 0, 5'd5, 1);
    check_eq("raw_busy5", {31'b0, busy_vec_o[5]}, 32'd1);
    issue_op(5'd5, 1, 5'd0, 0);
    check_eq("raw_stall", {31'b0, last_issue}, 32'd0);
    check_eq("raw_state", {30'b0, state_o}, 32'd1);
    cyc(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 1, 5'd5, 1, 0);
    check_eq("raw_bypass_issue", {31'b0, last_issue}, 32'd1);
    check_eq("raw_state_back",   {30'b0, state_o}, 32'd0);
    release_op(5'd0, 0);

    // pending-writer counter saturation blocks a further writer
    for (int i = 0; i < 3; i++) issue_op(5'd0, 0, 5'd6, 1);
    issue_op(5'd0, 0, 5'd6, 1);
    check_eq("waw_full_stall", {31'b0, last_issue}, 32'd0);
    for (int i = 0; i < 3; i++) release_op(5'd6, 1);

    // window full
    for (int i = 0; i < 4; i++) issue_op(5'd0, 0, 5'd0, 0);
    check_eq("full_inflight", {29'b0, inflight_o}, 32'd4);
    issue_op(5'd0, 0, 5'd0, 0);
    check_eq("full_stall", {31'b0, last_issue}, 32'd0);
    cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 5'd0, 0, 0);
    check_eq("full_bypass_issue", {31'b0, last_issue}, 32'd1);
    check_eq("full_bypass_inf",   {29'b0, inflight_o}, 32'd4);
    for (int i = 0; i < 4; i++) release_op(5'd0, 0);

    // serializing op waits for the window to drain
    issue_op(5'd0, 0, 5'd0, 0);
    issue_op(5'd0, 0, 5'd0, 0);
    cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0, 0);
    check_eq("drain_state", {30'b0, state_o}, 32'd2);
    cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 5'd0, 0, 0);
    check_eq("drain_hold", {31'b0, last_issue}, 32'd0);
    cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 5'd0, 0, 0);
    check_eq("drain_issue", {31'b0, last_issue}, 32'd1);
    release_op(5'd0, 0);

    // flush blocks a clean request; release on an empty window is sticky underflow
    cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 1);
    check_eq("flush_block", {31'b0, last_issue}, 32'd0);
    check_eq("flush_state", {30'b0, state_o}, 32'd0);
    check_eq("uf_clear",    {31'b0, underflow_o}, 32'd0);
    release_op(5'd0, 0);
    check_eq("uf_set", {31'b0, underflow_o}, 32'd1);
    cyc(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 0);
    check_eq("uf_sticky", {31'b0, underflow_o}, 32'd1);

    // random traffic over a small register range to provoke hazards
    for (int i = 0; i < 300; i++) begin
      cyc($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom_range(0, 1),
          5'($urandom_range(0, 7)), $urandom_range(0, 1), 5'($urandom_range(0, 7)),
          $urandom_range(0, 1), ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
          5'($urandom_range(0, 7)), $urandom_range(0, 1), ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
